// File: rtl/keypad_pkg.sv
// Shared widths, entry layout and read-FSM encoding for the keypad event FIFO.
package keypad_pkg;

  localparam int KP_POS_W   = 6;
  localparam int KP_ASCII_W = 8;
  localparam int KP_ENTRY_W = KP_POS_W + KP_ASCII_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic [KP_POS_W-1:0]   pos;
    logic [KP_ASCII_W-1:0] ascii;
  } kp_entry_t;

endpackage

// File: rtl/keypad_event_ram.sv
// Single-port synchronous event RAM; read data is registered and the array has no reset.
module keypad_event_ram
  import keypad_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [KP_ENTRY_W-1:0] wdata_i,
  output logic [KP_ENTRY_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [KP_ENTRY_W-1:0] mem_q [DEPTH];
  logic [KP_ENTRY_W-1:0] rdata_q;

  // One access per cycle: write when enabled, otherwise read the addressed word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/keypad_event_fifo_arbiter.sv
// Keypad event FIFO: skid register in front of a single-port RAM, shared between
// scanner writes and bus reads, with level, full, threshold-irq and overflow flags.
module keypad_event_fifo_arbiter
  import keypad_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                    system_clk_i,
  input  logic                    system_rst_i,
  input  logic                    fifo_write_enable_i,
  input  logic [KP_POS_W-1:0]     key_position_data_i,
  input  logic [KP_ASCII_W-1:0]   key_ascii_data_i,
  output logic                    position_fifo_full_o,
  output logic                    keycode_fifo_full_o,
  input  logic                    rd_req_i,
  output logic                    rd_ack_o,
  output logic [KP_POS_W-1:0]     rd_position_o,
  output logic [KP_ASCII_W-1:0]   rd_ascii_o,
  output logic                    rd_err_o,
  input  logic                    flush_i,
  input  logic [DEPTH_LOG2:0]     irq_threshold_i,
  output logic [DEPTH_LOG2:0]     fifo_level_o,
  output logic                    threshold_irq_o,
  output logic                    overflow_o,
  input  logic                    overflow_clr_i
);

  localparam int                DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  rd_state_e               state_q;
  logic                    rd_ack_q;
  logic                    rd_err_q;

  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  kp_entry_t               skid_q, skid_d;
  logic                    skid_valid_q, skid_valid_d;
  logic                    overflow_q, overflow_d;
  logic                    irq_q, irq_d;

  logic [DEPTH_LOG2:0]     level;
  logic                    full;
  logic                    drain;
  logic                    wr_accept;
  logic                    wr_drop;
  logic                    rd_accept;
  logic                    read_done;

  logic                    ram_we;
  logic [DEPTH_LOG2-1:0]   ram_addr;
  logic [KP_ENTRY_W-1:0]   ram_rdata;
  kp_entry_t               ram_entry;

  assign level = count_q + (DEPTH_LOG2 + 1)'(skid_valid_q);
  assign full  = (level == LEVEL_FULL);

  // Port grant: flush beats a drain, a drain beats a read issue.
  assign drain     = skid_valid_q & ~flush_i;
  assign wr_accept = fifo_write_enable_i & ~flush_i & ~full;
  assign wr_drop   = fifo_write_enable_i & ~flush_i & full;
  assign rd_accept = (state_q == ST_IDLE) & rd_req_i & ~skid_valid_q & ~flush_i;
  assign read_done = (state_q == ST_ACK) & ~rd_err_q & ~flush_i;

  assign ram_we   = drain;
  assign ram_addr = drain ? wr_ptr_q : rd_ptr_q;

  keypad_event_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk_i   (system_clk_i),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (skid_q),
    .rdata_o (ram_rdata)
  );

  // Next-state for pointers, count, skid and flags.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    overflow_d   = overflow_q;
    irq_d        = (irq_threshold_i != '0) && (level >= irq_threshold_i);

    if (flush_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      skid_valid_d = 1'b0;
    end else begin
      if (drain) begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (read_done) begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end
      // Drain and read completion in the same cycle cancel out.
      case ({drain, read_done})
        2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
        default: count_d = count_q;
      endcase
      // A pulse during a drain reloads the skid so back-to-back writes are kept.
      if (wr_accept) begin
        skid_d.pos   = key_position_data_i;
        skid_d.ascii = key_ascii_data_i;
        skid_valid_d = 1'b1;
      end else if (drain) begin
        skid_valid_d = 1'b0;
      end
    end

    // Set wins over clear.
    if (wr_drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr_i) begin
      overflow_d = 1'b0;
    end
  end

  // Datapath and flag registers.
  always_ff @(posedge system_clk_i or posedge system_rst_i) begin
    if (system_rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      overflow_q   <= overflow_d;
      irq_q        <= irq_d;
    end
  end

  // Read FSM: accept in idle, acknowledge for exactly one cycle.
  always_ff @(posedge system_clk_i or posedge system_rst_i) begin
    if (system_rst_i) begin
      state_q  <= ST_IDLE;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rd_ack_q <= 1'b0;
          rd_err_q <= 1'b0;
          if (rd_accept) begin
            state_q  <= ST_ACK;
            rd_ack_q <= 1'b1;
            rd_err_q <= (count_q == '0);
          end
        end
        ST_ACK: begin
          state_q  <= ST_IDLE;
          rd_ack_q <= 1'b0;
          rd_err_q <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          rd_ack_q <= 1'b0;
          rd_err_q <= 1'b0;
        end
      endcase
    end
  end

  // A flush landing in the ack cycle turns the completing read into an error.
  assign ram_entry     = ram_rdata;
  assign rd_ack_o      = rd_ack_q;
  assign rd_err_o      = rd_ack_q & (rd_err_q | flush_i);
  assign rd_position_o = (rd_ack_q & ~rd_err_o) ? ram_entry.pos   : '0;
  assign rd_ascii_o    = (rd_ack_q & ~rd_err_o) ? ram_entry.ascii : '0;

  assign position_fifo_full_o = full;
  assign keycode_fifo_full_o  = full;
  assign fifo_level_o         = level;
  assign threshold_irq_o      = irq_q;
  assign overflow_o           = overflow_q;

endmodule

// File: tb/tb_keypad_event_fifo_arbiter.sv
// Scoreboard bench for keypad_event_fifo_arbiter: accepted writes are queued,
// each read acknowledgement is checked against the queue head.
module tb_keypad_event_fifo_arbiter;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr;
  logic [5:0]    pos;
  logic [7:0]    asc;
  logic          pos_full, key_full;
  logic          rd_req;
  logic          rd_ack_o;
  logic [5:0]    rd_pos;
  logic [7:0]    rd_asc;
  logic          rd_err;
  logic          flush;
  logic [DL:0]   thr;
  logic [DL:0]   level;
  logic          irq;
  logic          ovf;
  logic          ovf_clr;

  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;
  logic [13:0]   exp_q [$];

  always #5 clk = ~clk;

  keypad_event_fifo_arbiter #(
    .DEPTH_LOG2(DL)
  ) dut (
    .system_clk_i         (clk),
    .system_rst_i         (rst),
    .fifo_write_enable_i  (wr),
    .key_position_data_i  (pos),
    .key_ascii_data_i     (asc),
    .position_fifo_full_o (pos_full),
    .keycode_fifo_full_o  (key_full),
    .rd_req_i             (rd_req),
    .rd_ack_o             (rd_ack_o),
    .rd_position_o        (rd_pos),
    .rd_ascii_o           (rd_asc),
    .rd_err_o             (rd_err),
    .flush_i              (flush),
    .irq_threshold_i      (thr),
    .fifo_level_o         (level),
    .threshold_irq_o      (irq),
    .overflow_o           (ovf),
    .overflow_clr_i       (ovf_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle write pulse; the model keeps it only if the FIFO had room.
  task automatic write_key(input logic [5:0] p, input logic [7:0] a);
    wr  = 1'b1;
    pos = p;
    asc = a;
    if (exp_q.size() < DEPTH) exp_q.push_back({p, a});
    step();
    wr = 1'b0;
  endtask

  // Raise rd_req, wait (bounded) for the ack, compare, then leave one idle cycle.
  task automatic do_read(input string tag, input bit exp_err, input int exp_lat);
    int          lat;
    bit          seen;
    logic [13:0] e;
    lat    = 0;
    seen   = 1'b0;
    rd_req = 1'b1;
    for (int i = 1; i <= 8 && !seen; i++) begin
      step();
      if (rd_ack_o) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check_eq({tag, "_acked"}, 32'(seen), 32'd1);
    if (seen) begin
      check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      e = '0;
      if (!exp_err && exp_q.size() > 0) e = exp_q.pop_front();
      check_eq({tag, "_err"}, 32'(rd_err), 32'(exp_err));
      check_eq({tag, "_pos"}, 32'(rd_pos), 32'(e[13:8]));
      check_eq({tag, "_ascii"}, 32'(rd_asc), 32'(e[7:0]));
    end
    rd_req = 1'b0;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr = 1'b0; pos = '0; asc = '0; rd_req = 1'b0;
    flush = 1'b0; thr = '0; ovf_clr = 1'b0;
    step(); step();
    check_eq("rst_ack",   32'(rd_ack_o), 32'd0);
    check_eq("rst_err",   32'(rd_err),   32'd0);
    check_eq("rst_level", 32'(level),    32'd0);
    check_eq("rst_full",  32'({pos_full, key_full}), 32'd0);
    check_eq("rst_irq",   32'(irq),      32'd0);
    check_eq("rst_ovf",   32'(ovf),      32'd0);
    check_eq("rst_data",  32'({rd_pos, rd_asc}), 32'd0);
    rst = 1'b0;
    step();

    // Single write then read.
    write_key(6'o21, 8'h57);
    check_eq("w1_level", 32'(level), 32'd1);
    step();
    do_read("r1", 1'b0, 1);
    check_eq("r1_level", 32'(level), 32'd0);

    // Fill to full, overflow, clear, set-wins-over-clear, drain.
    for (int i = 0; i < DEPTH; i++) write_key(6'(i + 3), 8'(8'h30 + i));
    check_eq("fill_level", 32'(level), 32'd16);
    check_eq("fill_pfull", 32'(pos_full), 32'd1);
    check_eq("fill_kfull", 32'(key_full), 32'd1);
    check_eq("fill_ovf0",  32'(ovf), 32'd0);
    check_eq("fill_irq_dis", 32'(irq), 32'd0);
    write_key(6'o77, 8'hEE);
    check_eq("drop_ovf",   32'(ovf), 32'd1);
    check_eq("drop_level", 32'(level), 32'd16);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check_eq("ovf_clr", 32'(ovf), 32'd0);
    ovf_clr = 1'b1;
    write_key(6'o76, 8'hED);
    ovf_clr = 1'b0;
    check_eq("ovf_set_wins", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) do_read("full_rd", 1'b0, 1);
    check_eq("full_rd_level", 32'(level), 32'd0);

    // Read arriving while a drain is pending is delayed and returns the older entry.
    write_key(6'o12, 8'h41);
    step();
    write_key(6'o34, 8'h42);
    do_read("drain_rd", 1'b0, 2);
    check_eq("drain_rd_level", 32'(level), 32'd1);
    do_read("drain_rd2", 1'b0, 1);

    // Empty read returns an error and leaves the pointers alone.
    do_read("empty_rd", 1'b1, 1);
    check_eq("empty_level", 32'(level), 32'd0);

    // 40 interleaved writes/reads across pointer wrap.
    for (int i = 0; i < 40; i++) begin
      write_key(6'($urandom), 8'($urandom));
      if (i >= 2) do_read("wrap_rd", 1'b0, 2);
    end
    do_read("wrap_tail", 1'b0, 1);
    do_read("wrap_tail", 1'b0, 1);
    check_eq("wrap_level", 32'(level), 32'd0);

    // Threshold interrupt lags the level by one cycle.
    thr = 5'd3;
    write_key(6'o01, 8'h61);
    write_key(6'o02, 8'h62);
    check_eq("irq_lvl2", 32'(irq), 32'd0);
    write_key(6'o03, 8'h63);
    check_eq("irq_level3", 32'(level), 32'd3);
    check_eq("irq_lag", 32'(irq), 32'd0);
    step();
    check_eq("irq_rise", 32'(irq), 32'd1);

    // Flush during the ack cycle of an in-flight read.
    rd_req = 1'b1;
    step();
    check_eq("fl_ack", 32'(rd_ack_o), 32'd1);
    rd_req = 1'b0;
    flush  = 1'b1;
    #1;
    check_eq("fl_err",  32'(rd_err), 32'd1);
    check_eq("fl_data", 32'({rd_pos, rd_asc}), 32'd0);
    step();
    flush = 1'b0;
    exp_q.delete();
    check_eq("fl_level", 32'(level), 32'd0);
    step();
    check_eq("fl_irq", 32'(irq), 32'd0);
    thr = '0;

    // Data written after the flush starts from a clean pointer state.
    write_key(6'o55, 8'h7A);
    step();
    do_read("post_flush", 1'b0, 1);

    // Asynchronous reset in the middle of an ack.
    write_key(6'o44, 8'h33);
    step();
    rd_req = 1'b1;
    step();
    check_eq("mid_ack", 32'(rd_ack_o), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ack",   32'(rd_ack_o), 32'd0);
    check_eq("mid_rst_level", 32'(level), 32'd0);
    rd_req = 1'b0;
    exp_q.delete();
    step();
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_event_fifo_arbiter.md
# keypad_event_fifo_arbiter

Buffers key events from the keypad scanner and shares one single-port event RAM between the scanner's write pulses and bus-side read requests. It sits between the keypad scanner's FIFO interface and the APB slave register block. It supplies the scanner's position/keycode full flags, plus a fill level, a threshold interrupt and a sticky overflow flag to software.

## Interface
Parameters:
- DEPTH_LOG2, 4: RAM depth is 2**DEPTH_LOG2 entries, each entry 14 bits {position[5:0], ascii[7:0]}.

Ports:
- system_clk_i  in  1  single clock, all logic on rising edge.
- system_rst_i  in  1  asynchronous, active-high reset.
- fifo_write_enable_i  in  1  one-cycle write pulse from the scanner.
- key_position_data_i  in  6  {row, col} sampled with the write pulse.
- key_ascii_data_i  in  8  ASCII code sampled with the write pulse.
- position_fifo_full_o  out  1  level == DEPTH.
- keycode_fifo_full_o  out  1  level == DEPTH; identical to the position full flag.
- rd_req_i  in  1  bus read request; held high until rd_ack_o is seen.
- rd_ack_o  out  1  one-cycle read completion.
- rd_position_o  out  6  entry position, valid only while rd_ack_o is high.
- rd_ascii_o  out  8  entry ASCII code, valid only while rd_ack_o is high.
- rd_err_o  out  1  high with rd_ack_o when the read found the FIFO empty or was flushed.
- flush_i  in  1  synchronous clear of the FIFO contents.
- irq_threshold_i  in  DEPTH_LOG2+1  fill level at which the interrupt asserts; 0 disables it.
- fifo_level_o  out  DEPTH_LOG2+1  stored entries plus the skid entry.
- threshold_irq_o  out  1  level interrupt.
- overflow_o  out  1  sticky flag for a dropped write.
- overflow_clr_i  in  1  clears overflow_o.

## Operation
- **Skid register.** A write pulse loads the 14-bit entry into a skid register and sets skid_valid.
- **RAM port grant, once per cycle, in priority order:**
  1. flush.
  2. Skid drain: RAM write at wr_ptr, wr_ptr++, count++.
  3. Read issue, only in ST_IDLE with rd_req_i high: RAM read at rd_ptr.
- **Back-to-back writes.** A write pulse in the same cycle as a skid drain reloads the skid, so back-to-back pulses are accepted.
- **Level.** level = count + skid_valid, width DEPTH_LOG2+1. Pointers are DEPTH_LOG2 bits and wrap from DEPTH-1 to 0.
- **Full / overflow.** A write pulse while level == DEPTH is dropped and sets overflow_o. If overflow_clr_i arrives in the same cycle, the set wins.
- **Read FSM:**
  - ST_IDLE → ST_ACK when rd_req_i is high and no drain is pending. The read is issued only if count != 0; otherwise it is marked as an error.
  - ST_ACK → ST_IDLE unconditionally. In ST_ACK, rd_ack_o = 1, and rd_ptr++ and count-- take effect at the end of the cycle for a successful read.
  - No request is accepted in ST_ACK. The requester drops rd_req_i the cycle after it sees the ack.
- **Error reads.** Error reads (empty, or flushed while in flight) return position 0 and ASCII 0 with rd_err_o = 1. Pointers are not changed.
- **Simultaneous drain and read completion.** A drain and a read completion in the same cycle leave count unchanged. A read returns the oldest entry; the skid entry is never bypassed to the read port.
- **Flush.** flush_i clears the pointers, count and skid_valid, and discards a write pulse in the same cycle. An in-flight read still acks, with rd_err_o = 1. overflow_o is unaffected by flush.
- **Interrupt.** threshold_irq_o = (irq_threshold_i != 0) && (level >= irq_threshold_i), registered.

## Timing
- **Reset values.** Every output is 0 during reset; the FSM is in ST_IDLE, pointers, count and skid_valid are 0, and the overflow flag is 0.
- **Write.**
  - Pulse at cycle N: skid valid at N+1, RAM write at N+1, count updated at N+2.
  - fifo_level_o and the full flags reflect the pulse from N+1.
- **Read.**
  - rd_req_i at cycle N with no pending drain: rd_ack_o at N+1 with the synchronous RAM output.
  - With a pending drain at N: ack at N+2.
- **Interrupt.** threshold_irq_o lags the level by 1 cycle.
- **Mid-operation reset.** Asynchronous reset mid-read drops the ack; reset outweighs everything.

## Structure
- Package keypad_pkg:
  - KP_POS_W = 6, KP_ASCII_W = 8, KP_ENTRY_W = 14.
  - Read-FSM state encoding ST_IDLE / ST_ACK.
- Sub-module keypad_event_ram: single-port synchronous RAM, DEPTH x KP_ENTRY_W, with we/addr/wdata/rdata and registered read data; no reset on the array.
- Arbitration, pointers, skid register, flags and FSM live in the top module.

## Test plan
- Reset, then one write of pos 6'o21, ASCII 8'h57 → level 1 at N+1; rd_req → ack one cycle later with 6'o21 / 8'h57, rd_err 0, level 0.
- Sixteen writes (DEPTH_LOG2=4), then a seventeenth → both full flags high at level 16, seventeenth dropped, overflow_o = 1; overflow_clr_i → 0.
- Write pulse and rd_req in the same cycle with one entry stored → ack delayed to N+2 with the older entry; level stays 1.
- rd_req on an empty FIFO → ack with rd_err 1, data 0, pointers unchanged.
- Fill and drain 40 entries interleaved → data returned in order across pointer wrap.
- irq_threshold_i = 3 → threshold_irq_o rises one cycle after level reaches 3; flush during an in-flight read → ack with rd_err 1, level 0, irq 0.
